// File: rtl/wb_find_pkg.sv
// Shared definitions for the sequence-search host: slave register map,
// result field layout and the host FSM states.
package wb_find_pkg;

  localparam logic [31:0] CTRL_OFS    = 32'h0000_0000;
  localparam logic [31:0] STATUS_OFS  = 32'h0000_0004;
  localparam logic [31:0] RESULT_BASE = 32'h0000_0010;
  localparam int          E_LSB       = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RST_SET,
    S_RST_CLR,
    S_POLL,
    S_WAIT,
    S_READ,
    S_EMIT
  } state_t;

  // Index of the lowest set bit, 0 when the vector is empty.
  function automatic logic [3:0] lowest_bit(input logic [15:0] v);
    lowest_bit = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (v[i]) lowest_bit = 4'(i);
    end
  endfunction

endpackage

// File: rtl/wb_master_port.sv
// Single-transfer Wishbone classic engine. done/timeout/rdat are valid in the
// cycle the transfer ends so the caller can launch the next one right away.
module wb_master_port #(
  parameter int ACK_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] adr,
  input  logic [31:0] wdat,
  output logic        done,
  output logic        timeout,
  output logic [31:0] rdat,
  output logic        cyc,
  output logic        stb,
  output logic        bus_we,
  output logic [31:0] bus_adr,
  output logic [31:0] bus_dat,
  input  logic        ack,
  input  logic [31:0] bus_rdat
);

  localparam int CW = $clog2(ACK_TIMEOUT + 1);

  logic [CW-1:0] wait_cnt;

  // An ack in the final counted cycle wins over the timeout.
  assign done    = stb && ack;
  assign timeout = stb && !ack && (wait_cnt == CW'(ACK_TIMEOUT - 1));
  assign rdat    = bus_rdat;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cyc      <= 1'b0;
      stb      <= 1'b0;
      bus_we   <= 1'b0;
      bus_adr  <= '0;
      bus_dat  <= '0;
      wait_cnt <= '0;
    end else if (stb) begin
      if (ack || timeout) begin
        cyc      <= 1'b0;
        stb      <= 1'b0;
        wait_cnt <= '0;
      end else begin
        wait_cnt <= wait_cnt + 1'b1;
      end
    end else if (req) begin
      cyc      <= 1'b1;
      stb      <= 1'b1;
      bus_we   <= we;
      bus_adr  <= adr;
      bus_dat  <= wdat;
      wait_cnt <= '0;
    end
  end

endmodule

// File: rtl/wb_find_host.sv
// Wishbone initiator that resets the parallel search slave, polls its status
// and streams each finished unit's {unit, seq, e} exactly once per run.
module wb_find_host
  import wb_find_pkg::*;
#(
  parameter logic [31:0] BASE_ADR       = 32'h3000_0000,
  parameter int          SEQ_WIDTH      = 8,
  parameter int          E_WIDTH        = 16,
  parameter int          PARALLEL_UNITS = 4,
  parameter int          POLL_GAP       = 16,
  parameter int          ACK_TIMEOUT    = 255,
  localparam int         UNIT_W         = (PARALLEL_UNITS > 1) ? $clog2(PARALLEL_UNITS) : 1
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_ni,
  output logic                 wbm_cyc_o,
  output logic                 wbm_stb_o,
  output logic                 wbm_we_o,
  output logic [3:0]           wbm_sel_o,
  output logic [31:0]          wbm_adr_o,
  output logic [31:0]          wbm_dat_o,
  input  logic                 wbm_ack_i,
  input  logic [31:0]          wbm_dat_i,
  input  logic                 i_start,
  output logic                 o_busy,
  output logic                 o_err,
  output logic                 o_res_valid,
  input  logic                 i_res_ready,
  output logic [UNIT_W-1:0]    o_res_unit,
  output logic [SEQ_WIDTH-1:0] o_res_seq,
  output logic [E_WIDTH-1:0]   o_res_e
);

  localparam int GAP_W = $clog2(POLL_GAP + 1);
  localparam logic [PARALLEL_UNITS-1:0] ALL_UNITS = '1;

  state_t                    state;
  logic                      req, req_we, done, timeout;
  logic [31:0]               req_adr, req_dat, rdat;
  logic [PARALLEL_UNITS-1:0] reported, pending, fresh, unit_bit, pending_left;
  logic [GAP_W-1:0]          gap_cnt;
  logic [UNIT_W-1:0]         fresh_unit, next_unit;
  logic                      unused_rdat;

  function automatic logic [31:0] result_adr(input logic [UNIT_W-1:0] u);
    return BASE_ADR + RESULT_BASE + (32'(u) << 2);
  endfunction

  assign wbm_sel_o    = 4'hF;
  assign fresh        = rdat[PARALLEL_UNITS-1:0] & ~reported;
  assign unit_bit     = PARALLEL_UNITS'(1) << o_res_unit;
  assign pending_left = pending & ~unit_bit;
  assign fresh_unit   = UNIT_W'(lowest_bit(16'(fresh)));
  assign next_unit    = UNIT_W'(lowest_bit(16'(pending_left)));
  assign unused_rdat  = ^rdat;

  wb_master_port #(.ACK_TIMEOUT(ACK_TIMEOUT)) u_port (
    .clk      (wb_clk_i),
    .rst_n    (wb_rst_ni),
    .req      (req),
    .we       (req_we),
    .adr      (req_adr),
    .wdat     (req_dat),
    .done     (done),
    .timeout  (timeout),
    .rdat     (rdat),
    .cyc      (wbm_cyc_o),
    .stb      (wbm_stb_o),
    .bus_we   (wbm_we_o),
    .bus_adr  (wbm_adr_o),
    .bus_dat  (wbm_dat_o),
    .ack      (wbm_ack_i),
    .bus_rdat (wbm_dat_i)
  );

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      state       <= S_IDLE;
      req         <= 1'b0;
      req_we      <= 1'b0;
      req_adr     <= '0;
      req_dat     <= '0;
      o_busy      <= 1'b0;
      o_err       <= 1'b0;
      o_res_valid <= 1'b0;
      o_res_unit  <= '0;
      o_res_seq   <= '0;
      o_res_e     <= '0;
      reported    <= '0;
      pending     <= '0;
      gap_cnt     <= '0;
    end else begin
      req <= 1'b0;
      if (timeout) begin
        state       <= S_IDLE;
        o_err       <= 1'b1;
        o_busy      <= 1'b0;
        o_res_valid <= 1'b0;
      end else begin
        case (state)
          S_IDLE: if (i_start) begin
            o_err    <= 1'b0;
            o_busy   <= 1'b1;
            reported <= '0;
            pending  <= '0;
            state    <= S_RST_SET;
            req      <= 1'b1;
            req_we   <= 1'b1;
            req_adr  <= BASE_ADR + CTRL_OFS;
            req_dat  <= 32'd1;
          end
          S_RST_SET: if (done) begin
            state   <= S_RST_CLR;
            req     <= 1'b1;
            req_we  <= 1'b1;
            req_adr <= BASE_ADR + CTRL_OFS;
            req_dat <= '0;
          end
          S_RST_CLR: if (done) begin
            state   <= S_POLL;
            req     <= 1'b1;
            req_we  <= 1'b0;
            req_adr <= BASE_ADR + STATUS_OFS;
          end
          S_POLL: if (done) begin
            if (|fresh) begin
              pending    <= fresh;
              o_res_unit <= fresh_unit;
              state      <= S_READ;
              req        <= 1'b1;
              req_we     <= 1'b0;
              req_adr    <= result_adr(fresh_unit);
            end else if (POLL_GAP <= 1) begin
              req <= 1'b1;
            end else begin
              state   <= S_WAIT;
              gap_cnt <= GAP_W'(1);
            end
          end
          // The launch edge itself supplies the last idle cycle of the gap.
          S_WAIT: if (gap_cnt >= GAP_W'(POLL_GAP - 1)) begin
            state   <= S_POLL;
            req     <= 1'b1;
            req_we  <= 1'b0;
            req_adr <= BASE_ADR + STATUS_OFS;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
          S_READ: if (done) begin
            o_res_seq   <= rdat[SEQ_WIDTH-1:0];
            o_res_e     <= rdat[E_LSB +: E_WIDTH];
            o_res_valid <= 1'b1;
            state       <= S_EMIT;
          end
          S_EMIT: if (i_res_ready) begin
            o_res_valid <= 1'b0;
            reported    <= reported | unit_bit;
            pending     <= pending_left;
            if (|pending_left) begin
              o_res_unit <= next_unit;
              state      <= S_READ;
              req        <= 1'b1;
              req_we     <= 1'b0;
              req_adr    <= result_adr(next_unit);
            end else if ((reported | unit_bit) == ALL_UNITS) begin
              state  <= S_IDLE;
              o_busy <= 1'b0;
            end else begin
              state   <= S_POLL;
              req     <= 1'b1;
              req_we  <= 1'b0;
              req_adr <= BASE_ADR + STATUS_OFS;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_wb_find_host.sv
// Bench for wb_find_host: a Wishbone slave model, a bus monitor and a
// high-level reference of the poll/read/emit sequence for each run.
module tb_wb_find_host;

  localparam logic [31:0] BASE     = 32'h3000_0000;
  localparam int          POLL_GAP = 16;

  typedef struct {
    bit          we;
    logic [31:0] adr;
    logic [31:0] dat;
    int          gap;
  } txn_t;

  typedef struct {
    int          unit;
    logic [7:0]  seq;
    logic [15:0] e;
  } res_t;

  typedef struct packed {
    logic [3:0][31:0] st;
    logic [31:0]      n_st;
    logic [15:0]      exp_order;
    logic [31:0]      exp_nres;
    logic [31:0]      exp_polls;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n, cyc, stb, we, ack, i_start, busy, err, valid, ready;
  logic [3:0]  sel;
  logic [31:0] adr, dat_o, rdata;
  logic [1:0]  unit;
  logic [7:0]  seq;
  logic [15:0] e;

  int   checks = 0, errors = 0;
  txn_t txn_log[$], exp_txn[$];
  res_t got_res[$], exp_res[$];

  logic [31:0] status_words [16];
  logic [31:0] result_words [4];
  int   n_status = 1, stat_idx = 0, ack_delay = 0, slave_wait = 0, ready_mode = 0;
  bit   mute_status = 0;
  int   idle_cnt = 1000, stb_len = 0, last_stb_len = 0, bad_bus = 0;
  bit   prev_stb = 0;

  always #5 clk = ~clk;

  wb_find_host dut (
    .wb_clk_i    (clk),
    .wb_rst_ni   (rst_n),
    .wbm_cyc_o   (cyc),
    .wbm_stb_o   (stb),
    .wbm_we_o    (we),
    .wbm_sel_o   (sel),
    .wbm_adr_o   (adr),
    .wbm_dat_o   (dat_o),
    .wbm_ack_i   (ack),
    .wbm_dat_i   (rdata),
    .i_start     (i_start),
    .o_busy      (busy),
    .o_err       (err),
    .o_res_valid (valid),
    .i_res_ready (ready),
    .o_res_unit  (unit),
    .o_res_seq   (seq),
    .o_res_e     (e)
  );

  // Slave model: acks after ack_delay extra wait cycles, status words in order
  always @(posedge clk) begin
    int k;
    if (!rst_n) begin
      ack <= 1'b0;
      slave_wait <= 0;
    end else if (cyc && stb && !ack) begin
      if (mute_status && adr == BASE + 32'h4) begin
        slave_wait <= 0;
      end else if (slave_wait >= ack_delay) begin
        ack <= 1'b1;
        slave_wait <= 0;
        if (!we) begin
          if (adr == BASE + 32'h4) begin
            rdata <= status_words[stat_idx];
            if (stat_idx < n_status - 1) stat_idx = stat_idx + 1;
          end else begin
            k = int'((adr - BASE - 32'h10) >> 2);
            rdata <= (k >= 0 && k < 4) ? result_words[k] : 32'hDEAD_BEEF;
          end
        end
      end else begin
        slave_wait <= slave_wait + 1;
      end
    end else begin
      ack <= 1'b0;
      slave_wait <= 0;
    end
  end

  // Bus monitor: logs each transfer with its preceding idle gap
  always @(negedge clk) begin
    if (stb) begin
      if (!prev_stb) begin
        txn_log.push_back('{we, adr, dat_o, idle_cnt});
        stb_len = 0;
      end else if (txn_log.size() > 0 &&
                   (we != txn_log[$].we || adr != txn_log[$].adr || dat_o != txn_log[$].dat)) begin
        bad_bus++;
      end
      stb_len++;
    end else begin
      if (prev_stb) begin
        last_stb_len = stb_len;
        idle_cnt = 0;
      end
      idle_cnt++;
    end
    if (cyc != stb || sel != 4'hF) bad_bus++;
    prev_stb = stb;
  end

  // Consumer: picks ready for the coming edge and records accepted results
  always @(negedge clk) begin
    bit r;
    case (ready_mode)
      0:       r = 1'b1;
      1:       r = 1'($urandom_range(0, 1));
      default: r = 1'b0;
    endcase
    ready = r;
    if (valid && r) got_res.push_back('{int'(unit), seq, e});
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Reference: walk the status sequence and derive transfers and results
  task automatic buildModel();
    logic [3:0] rep, pend;
    int idx, gap;
    exp_txn.delete();
    exp_res.delete();
    exp_txn.push_back('{1'b1, BASE, 32'd1, -1});
    exp_txn.push_back('{1'b1, BASE, 32'd0, 1});
    rep = 4'h0;
    idx = 0;
    gap = 1;
    for (int it = 0; it < 64 && rep != 4'hF; it++) begin
      exp_txn.push_back('{1'b0, BASE + 32'h4, 32'd0, gap});
      pend = status_words[idx][3:0] & ~rep;
      if (idx < n_status - 1) idx++;
      if (pend == 4'h0) begin
        gap = POLL_GAP;
      end else begin
        gap = 1;
        for (int u = 0; u < 4; u++) begin
          if (pend[u]) begin
            exp_txn.push_back('{1'b0, BASE + 32'h10 + 32'(4 * u), 32'd0, gap});
            exp_res.push_back('{u, result_words[u][7:0], result_words[u][31:16]});
            rep[u] = 1'b1;
            gap = -1;
          end
        end
      end
    end
  endtask

  task automatic applyStimulus();
    txn_log.delete();
    got_res.delete();
    stat_idx = 0;
    bad_bus = 0;
    buildModel();
    @(negedge clk) i_start = 1'b1;
    @(negedge clk) i_start = 1'b0;
  endtask

  task automatic waitIdle(input int budget, input bit extra_starts, input string tag);
    int n = 0;
    while (busy && n < budget) begin
      @(negedge clk);
      i_start = extra_starts && busy && (n % 9 == 4);
      n++;
    end
    i_start = 1'b0;
    if (n >= budget) checkOutput({tag, " run did not finish"}, 64'(busy), 64'd0);
  endtask

  task automatic compareRun(input string tag);
    int n;
    logic [15:0] ga, gx;
    checkOutput({tag, " transfer count"}, 64'(txn_log.size()), 64'(exp_txn.size()));
    n = (txn_log.size() < exp_txn.size()) ? txn_log.size() : exp_txn.size();
    for (int i = 0; i < n; i++) begin
      gx = (exp_txn[i].gap < 0) ? 16'hFFFF : 16'(exp_txn[i].gap);
      ga = (exp_txn[i].gap < 0 && txn_log[i].gap >= 1) ? 16'hFFFF : 16'(txn_log[i].gap);
      checkOutput($sformatf("%s txn%0d we/adr/gap", tag, i),
                  {15'd0, txn_log[i].we, txn_log[i].adr, ga},
                  {15'd0, exp_txn[i].we, exp_txn[i].adr, gx});
      if (exp_txn[i].we)
        checkOutput($sformatf("%s txn%0d wdata", tag, i), 64'(txn_log[i].dat), 64'(exp_txn[i].dat));
    end
    checkOutput({tag, " result count"}, 64'(got_res.size()), 64'(exp_res.size()));
    n = (got_res.size() < exp_res.size()) ? got_res.size() : exp_res.size();
    for (int i = 0; i < n; i++) begin
      checkOutput($sformatf("%s result%0d", tag, i),
                  {8'(got_res[i].unit), got_res[i].seq, got_res[i].e},
                  {8'(exp_res[i].unit), exp_res[i].seq, exp_res[i].e});
    end
    checkOutput({tag, " bus protocol"}, 64'(bad_bus), 64'd0);
    checkOutput({tag, " end flags"}, {62'd0, busy, err}, 64'd0);
  endtask

  task automatic loadVec(input vec_t v);
    for (int k = 0; k < 4; k++) status_words[k] = v.st[k];
    n_status = int'(v.n_st);
    for (int u = 0; u < 4; u++)
      result_words[u] = {16'h1234 + 16'(u), 8'hA5, 8'h3A + 8'(u)};
  endtask

  initial begin
    vec_t vecs[5];
    int polls, n;
    logic [15:0] order;
    logic [31:0] held;

    vecs[0] = '{{32'hF, 32'h5, 32'h0, 32'h0}, 32'd4, 16'h3120, 32'd4, 32'd4};
    vecs[1] = '{{32'hF, 32'hF, 32'hF, 32'hF}, 32'd1, 16'h3210, 32'd4, 32'd1};
    vecs[2] = '{{32'hC, 32'hC, 32'h3, 32'hF3}, 32'd3, 16'h3210, 32'd4, 32'd3};
    vecs[3] = '{{32'hF, 32'hF, 32'hA, 32'h8}, 32'd3, 16'h2013, 32'd4, 32'd3};
    vecs[4] = '{{32'hF, 32'hF, 32'hF, 32'hFFFF_FFF0}, 32'd2, 16'h3210, 32'd4, 32'd2};

    rst_n = 1'b0;
    i_start = 1'b0;
    rdata = 32'd0;
    repeat (3) @(negedge clk);
    checkOutput("reset bus ctrl", {57'd0, cyc, stb, we, sel}, 64'h0F);
    checkOutput("reset adr/wdata", {adr, dat_o}, 64'd0);
    checkOutput("reset flags", {61'd0, busy, err, valid}, 64'd0);
    checkOutput("reset result", {38'd0, unit, seq, e}, 64'd0);
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      loadVec(vecs[i]);
      ready_mode = 0;
      ack_delay = 0;
      applyStimulus();
      waitIdle(3000, 1'b0, $sformatf("vec%0d", i));
      compareRun($sformatf("vec%0d", i));
      polls = 0;
      foreach (txn_log[j]) if (txn_log[j].adr == BASE + 32'h4) polls++;
      order = 16'h0;
      foreach (got_res[j]) if (j < 4) order[4*j +: 4] = 4'(got_res[j].unit);
      checkOutput($sformatf("vec%0d polls", i), 64'(polls), 64'(vecs[i].exp_polls));
      checkOutput($sformatf("vec%0d order", i), 64'(order), 64'(vecs[i].exp_order));
      checkOutput($sformatf("vec%0d nres", i), 64'(got_res.size()), 64'(vecs[i].exp_nres));
    end

    // Start pulses while busy must not disturb the run
    loadVec(vecs[0]);
    applyStimulus();
    waitIdle(3000, 1'b1, "dblstart");
    compareRun("dblstart");

    // Consumer stall: result must stay put until accepted
    loadVec(vecs[1]);
    ready_mode = 2;
    applyStimulus();
    n = 0;
    while (!valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput("stall valid seen", 64'(valid), 64'd1);
    held = {6'd0, unit, seq, e};
    repeat (10) begin
      @(negedge clk);
      checkOutput("stall hold", {31'd0, valid, 6'd0, unit, seq, e}, {31'd0, 1'b1, held});
    end
    ready_mode = 0;
    waitIdle(3000, 1'b0, "stall");
    compareRun("stall");

    // Randomised runs against the reference
    for (int r = 0; r < 6; r++) begin
      n_status = $urandom_range(1, 5);
      for (int k = 0; k < n_status - 1; k++) status_words[k] = $urandom;
      status_words[n_status - 1] = $urandom | 32'hF;
      for (int u = 0; u < 4; u++) result_words[u] = $urandom;
      ready_mode = 1;
      ack_delay = $urandom_range(0, 3);
      applyStimulus();
      waitIdle(5000, 1'b0, $sformatf("rand%0d", r));
      compareRun($sformatf("rand%0d", r));
    end
    ready_mode = 0;
    ack_delay = 0;

    // Status read never acknowledged
    loadVec(vecs[1]);
    mute_status = 1'b1;
    applyStimulus();
    waitIdle(2000, 1'b0, "timeout");
    @(negedge clk);
    checkOutput("timeout stb length", 64'(last_stb_len), 64'd255);
    checkOutput("timeout flags", {62'd0, busy, err}, 64'd1);
    checkOutput("timeout bus idle", {62'd0, cyc, stb}, 64'd0);
    checkOutput("timeout no result", 64'(got_res.size()), 64'd0);
    checkOutput("timeout transfers", 64'(txn_log.size()), 64'd3);
    mute_status = 1'b0;
    applyStimulus();
    checkOutput("timeout err cleared", 64'(err), 64'd0);
    waitIdle(3000, 1'b0, "post-timeout");
    compareRun("post-timeout");

    // Reset while a result read is outstanding
    loadVec(vecs[1]);
    ack_delay = 40;
    applyStimulus();
    n = 0;
    while (!(stb && adr == BASE + 32'h10) && n < 300) begin
      @(negedge clk);
      n++;
    end
    checkOutput("reset reached read", 64'(stb && adr == BASE + 32'h10), 64'd1);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("midreset outputs", {60'd0, cyc, stb, valid, busy}, 64'd0);
    rst_n = 1'b1;
    n = txn_log.size();
    repeat (30) @(negedge clk);
    checkOutput("midreset bus quiet", {31'd0, stb, 32'(txn_log.size())}, {31'd0, 1'b0, 32'(n)});
    ack_delay = 0;
    applyStimulus();
    waitIdle(3000, 1'b0, "post-reset");
    compareRun("post-reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/wb_find_host.md
Name: wb_find_host

Overview:
- Wishbone classic initiator that drives the parallel sequence-search slave from the other side of the bus.
- Sequence per run: issues a soft-reset pulse to the slave, then polls its status word until units finish.
- For each finished unit, reads its result word once and presents {unit, seq, e} on a valid/ready stream.
- Sits between a local controller (start/busy/err) and the search slave; lets hardware run searches without the management CPU.

Parameters:
- BASE_ADR, 32'h3000_0000, slave base address.
- SEQ_WIDTH, 8, width of seq field.
- E_WIDTH, 16, width of e field (≤16).
- PARALLEL_UNITS, 4, number of search units (≤16).
- POLL_GAP, 16, idle cycles between status reads (≥1).
- ACK_TIMEOUT, 255, max cycles waiting for ack before abort.

Ports:
- wb_clk_i  in  1  clock.
- wb_rst_ni  in  1  synchronous active-low reset.
- wbm_cyc_o  out  1  bus cycle.
- wbm_stb_o  out  1  strobe.
- wbm_we_o  out  1  write enable.
- wbm_sel_o  out  4  byte select, always 4'hF.
- wbm_adr_o  out  32  address.
- wbm_dat_o  out  32  write data.
- wbm_ack_i  in  1  slave ack.
- wbm_dat_i  in  32  read data.
- i_start  in  1  one-cycle pulse; starts a run when idle.
- o_busy  out  1  high from accepted start until run end.
- o_err  out  1  sticky ack-timeout flag; cleared by next accepted start.
- o_res_valid  out  1  result available.
- i_res_ready  in  1  consumer accepts result.
- o_res_unit  out  clog2(PARALLEL_UNITS), min 1  unit index.
- o_res_seq  out  SEQ_WIDTH  found sequence.
- o_res_e  out  E_WIDTH  found e.

Behaviour:
Slave register map (byte offsets from BASE_ADR):
- 0x00 CTRL: bit0 = soft reset.
- 0x04 STATUS: bits[PARALLEL_UNITS-1:0] = done.
- 0x10+4*i RESULT i: [SEQ_WIDTH-1:0] = seq, [16+:E_WIDTH] = e.

Reset values: all outputs 0 except wbm_sel_o = 4'hF; reported mask 0; FSM in IDLE.

Bus transfer:
- Assert cyc, stb, adr, we, dat together on one edge.
- Hold them stable until the cycle in which ack is sampled high.
- Deassert cyc and stb on the following edge.
- Guarantee at least one idle cycle between transfers; no pipelining.
- Read data is captured on the ack cycle.

FSM:
- IDLE: on i_start, clear o_err and the reported mask, set o_busy, go RST_SET. i_start in any other state is ignored.
- RST_SET: write CTRL = 1, go RST_CLR.
- RST_CLR: write CTRL = 0, go POLL.
- POLL: read STATUS and compute pending = done & ~reported. If pending ≠ 0, go READ for the lowest set bit. Else go WAIT.
- WAIT: count POLL_GAP idle cycles, then go POLL.
- READ: read RESULT[unit], latch the fields, set o_res_valid, go EMIT.
- EMIT: hold valid and data stable until valid & ready. On that cycle drop valid and set the reported bit. If pending still has bits, go READ for the next lowest. Else if all units are reported, go IDLE with o_busy low. Else go POLL.
- Timeout: a counter runs while stb is high and ack is low. When it reaches ACK_TIMEOUT, drop cyc/stb on the next edge, set o_err, clear o_busy, go IDLE. No partial result is emitted.
- An ack arriving on the same cycle the counter reaches ACK_TIMEOUT counts as success.

Boundary conditions:
- Several done bits in one STATUS read: results are emitted in ascending unit order with no re-poll in between.
- Done bits at positions ≥ PARALLEL_UNITS are ignored.
- A unit never reported twice per run.
- Reset asserted mid-transfer: cyc/stb low on the next edge; no further bus activity.

Decomposition:
- Package wb_find_pkg holds:
  - register offsets (CTRL 0x00, STATUS 0x04, RESULT_BASE 0x10);
  - field positions (E_LSB = 16);
  - the FSM state enum.
  The slave side is then updated to use the same offsets.
- One sub-module, wb_master_port: single-transfer engine with req/we/adr/wdat in and done/rdat/timeout out, containing the timeout counter. The FSM lives in wb_find_host.

Test Plan:
- Start with a responsive slave model (ack after 1 cycle) → writes CTRL = 1 then CTRL = 0 at 0x3000_0000, followed by a read at 0x3000_0004; sel = F; exactly one idle cycle between cycles.
- STATUS returns 0x0 twice, then 0x5 → gap of 16 idle cycles between polls. Reads at 0x3000_0010 and 0x3000_0018 follow. Results: unit0 (seq = 0x3A, e = 0x1234), then unit2. No re-read of unit0 on the next poll.
- STATUS returns 0xF; i_res_ready held low for 10 cycles → o_res_valid stays high with stable data. After 4 accepts, o_busy falls and o_err = 0.
- Slave never acks on the STATUS read → stb drops after 255 cycles of waiting; o_err = 1 and o_busy = 0. The next i_start clears o_err.
- wb_rst_ni low while mid-READ with stb high → cyc/stb = 0 and o_res_valid = 0 on the next edge; FSM in IDLE.
- i_start pulsed while busy → ignored; transaction sequence identical to the single-start run.
